// File: rtl/terminal_ingress_fifo.sv
// Ingress FIFO between a terminal agent and its mesh terminal port.
// Buffers host packets, presents the head first-word-fall-through to the mesh,
// and screens destinations: illegal or self-addressed packets are dropped and counted.
module terminal_ingress_fifo #(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 40,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int ID_ROW     = 0,
    parameter int ID_COL     = 0,
    parameter int BDCST_EN   = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic [PCKG_SZ-1:0]                    data_in,
    output logic                                  full,
    input  logic                                  popin,
    output logic                                  pndng_i_in,
    output logic [PCKG_SZ-1:0]                    data_out_i_in,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       count,
    output logic [15:0]                           drop_cnt,
    output logic                                  overflow,
    input  logic                                  clr_stat
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Header-field comparison constants, sized to the 4-bit address fields
    localparam logic [3:0] ROWS_L    = 4'(ROWS);
    localparam logic [3:0] ROWS_P1   = 4'(ROWS + 1);
    localparam logic [3:0] COLS_L    = 4'(COLUMS);
    localparam logic [3:0] COLS_P1   = 4'(COLUMS + 1);
    localparam logic [3:0] SELF_ROW  = 4'(ID_ROW);
    localparam logic [3:0] SELF_COL  = 4'(ID_COL);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [15:0]   drop_cnt_reg;
    logic          overflow_reg;

    logic [3:0] dst_row;
    logic [3:0] dst_col;
    logic       dst_legal;
    logic       is_full;
    logic       is_pending;
    logic       do_accept;
    logic       do_pop;
    logic       do_drop;
    logic       do_overflow;

    assign is_full    = (count_reg == CNT_FULL);
    assign is_pending = (count_reg != '0);

    // Destination screening and push/pop qualification
    always_comb begin
        dst_row   = data_in[PCKG_SZ-9 -: 4];
        dst_col   = data_in[PCKG_SZ-13 -: 4];
        dst_legal = 1'b0;
        // West/east edge terminals: row inside the mesh, column just outside it
        if ((dst_row >= 4'd1) && (dst_row <= ROWS_L) &&
            ((dst_col == 4'd0) || (dst_col == COLS_P1)))
            dst_legal = 1'b1;
        // North/south edge terminals: column inside the mesh, row just outside it
        if ((dst_col >= 4'd1) && (dst_col <= COLS_L) &&
            ((dst_row == 4'd0) || (dst_row == ROWS_P1)))
            dst_legal = 1'b1;
        if ((BDCST_EN != 0) && (dst_row == 4'hF) && (dst_col == 4'hF))
            dst_legal = 1'b1;
        // A terminal never sends to itself
        if ((dst_row == SELF_ROW) && (dst_col == SELF_COL))
            dst_legal = 1'b0;

        do_pop      = popin & is_pending;
        do_accept   = push & dst_legal & (~is_full | popin);
        do_drop     = push & ~dst_legal;
        do_overflow = push & dst_legal & is_full & ~popin;
    end

    // Packet storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_accept)
            mem[wr_ptr_reg] <= data_in;
    end

    // Pointer and occupancy bookkeeping with explicit wrap at FIFO_DEPTH-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_accept)
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            if (do_accept && !do_pop)
                count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_accept)
                count_reg <= count_reg - 1'b1;
        end
    end

    // Statistics: saturating drop counter and sticky overflow, clear has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else if (clr_stat) begin
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_drop && (drop_cnt_reg != 16'hFFFF))
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            if (do_overflow)
                overflow_reg <= 1'b1;
        end
    end

    assign full          = is_full;
    assign pndng_i_in    = is_pending;
    assign count         = count_reg;
    assign drop_cnt      = drop_cnt_reg;
    assign overflow      = overflow_reg;
    assign data_out_i_in = is_pending ? mem[rd_ptr_reg] : '0;

endmodule
